// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM states,
// error cause codes and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rxState_t;

    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    function automatic logic oddParityOk(input logic [7:0] byteVal, input logic parityBit);
        return ^{byteVal, parityBit};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only when a pop
// frees the head in the same cycle. Shared with the UART receive path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers rely on DEPTH being a power of two so they wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checking, glitch rejection, timeout
// and a show-ahead receive FIFO. Define PS2_RX_INHIBIT_EN to add ps2ClkOe.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int CNT_BITS = 12,
    parameter int MIN_LOW  = 2,
    parameter int TIMEOUT  = 4000,
    parameter int DEPTH    = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    input  logic        rdEn,
    input  logic        clrOvf,
    output logic [7:0]  data,
    output logic        dataReady,
    output logic [AW:0] count,
    output logic        error,
    output logic [1:0]  errCode,
    output logic        overflow
`ifdef PS2_RX_INHIBIT_EN
    ,
    output logic        ps2ClkOe
`endif
);

    localparam logic [CNT_BITS-1:0] MIN_LOW_C = CNT_BITS'(MIN_LOW);
    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] ONE_C     = CNT_BITS'(1);

    logic [1:0]          clkSync;
    logic [1:0]          dataSync;
    logic                ps2ClkS;
    logic                ps2DataS;
    logic                clkPrev;
    logic [CNT_BITS-1:0] phaseCnt;
    logic [CNT_BITS-1:0] curLen;
    logic                sample;
    logic                timeout;

    rxState_t   state, stateNext;
    logic [2:0] bitCnt, bitCntNext;
    logic [7:0] shiftReg, shiftNext;
    logic       parityOk, parityOkNext;
    logic       frameGood;
    logic       frameErr;
    logic [1:0] errCause;

    logic       fifoFull;
    logic       fifoEmpty;

    // Synchronisers start at the idle-bus level so reset never fakes a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
        end
    end

    assign ps2ClkS  = clkSync[1];
    assign ps2DataS = dataSync[1];

    // curLen is the length of the current ps2Clk phase including this cycle.
    always_comb begin
        curLen = phaseCnt;
        if (ps2ClkS != clkPrev) begin
            curLen = ONE_C;
        end else if (!(&phaseCnt)) begin
            curLen = phaseCnt + ONE_C;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkPrev  <= 1'b1;
            phaseCnt <= '0;
        end else begin
            clkPrev  <= ps2ClkS;
            phaseCnt <= curLen;
        end
    end

    assign sample  = !ps2ClkS && (curLen == MIN_LOW_C);
    assign timeout = (state != IDLE) && (curLen >= TIMEOUT_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            parityOk <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            parityOk <= parityOkNext;
        end
    end

    // Timeout pre-empts any sample; at the stop bit a bad stop outranks bad parity.
    always_comb begin
        stateNext    = state;
        bitCntNext   = bitCnt;
        shiftNext    = shiftReg;
        parityOkNext = parityOk;
        frameGood    = 1'b0;
        frameErr     = 1'b0;
        errCause     = errCode;
        if (timeout) begin
            stateNext = IDLE;
            frameErr  = 1'b1;
            errCause  = ERR_TIMEOUT;
        end else if (sample) begin
            case (state)
                IDLE: begin
                    if (!ps2DataS) begin
                        stateNext  = DATA;
                        bitCntNext = '0;
                    end
                end
                DATA: begin
                    shiftNext  = {ps2DataS, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'(DATA_BITS - 1)) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parityOkNext = oddParityOk(shiftReg, ps2DataS);
                    stateNext    = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    if (!ps2DataS) begin
                        frameErr = 1'b1;
                        errCause = ERR_STOP;
                    end else if (!parityOk) begin
                        frameErr = 1'b1;
                        errCause = ERR_PARITY;
                    end else begin
                        frameGood = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error   <= 1'b0;
            errCode <= '0;
        end else begin
            error   <= frameErr;
            errCode <= errCause;
        end
    end

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (frameGood),
        .pop    (rdEn),
        .wrData (shiftReg),
        .rdData (data),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (count)
    );

    assign dataReady = !fifoEmpty;

    // A fresh drop in the same cycle as clrOvf keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (frameGood && fifoFull && !rdEn) begin
            overflow <= 1'b1;
        end else if (clrOvf) begin
            overflow <= 1'b0;
        end
    end

`ifdef PS2_RX_INHIBIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2ClkOe <= 1'b0;
        end else begin
            ps2ClkOe <= fifoFull && (state == IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: directed PS/2 frames with a scoreboard of
// expected popped bytes and expected error codes checked by a monitor.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic        clk;
    logic        reset;
    logic        ps2Clk;
    logic        ps2Data;
    logic        rdEn;
    logic        clrOvf;
    logic [7:0]  data;
    logic        dataReady;
    logic [AW:0] count;
    logic        error;
    logic [1:0]  errCode;
    logic        overflow;
`ifdef PS2_RX_INHIBIT_EN
    logic        ps2ClkOe;
`endif

    int checks = 0;
    int fails  = 0;

    logic [7:0] expQ[$];
    logic [1:0] errQ[$];

    ps2_rx_fifo #(
        .CNT_BITS(12),
        .MIN_LOW (2),
        .TIMEOUT (20),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .rdEn      (rdEn),
        .clrOvf    (clrOvf),
        .data      (data),
        .dataReady (dataReady),
        .count     (count),
        .error     (error),
        .errCode   (errCode),
        .overflow  (overflow)
`ifdef PS2_RX_INHIBIT_EN
        ,
        .ps2ClkOe  (ps2ClkOe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        ps2Data = b;
        ps2Clk  = 1'b0;
        tick(3);
        ps2Clk  = 1'b1;
        tick(3);
    endtask

    // One full frame; popOnStop raises rdEn on the exact cycle of the stop sample.
    task automatic applyStimulus(input logic [7:0] byteVal, input logic badParity,
                                 input logic stopBit, input logic popOnStop);
        logic parityBit;
        parityBit = ~(^byteVal) ^ badParity;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(byteVal[i]);
        end
        sendBit(parityBit);
        ps2Data = stopBit;
        ps2Clk  = 1'b0;
        tick(3);
        if (popOnStop) rdEn = 1'b1;
        ps2Clk = 1'b1;
        tick(1);
        rdEn    = 1'b0;
        ps2Data = 1'b1;
        tick(6);
    endtask

    task automatic applyPop(input int n);
        repeat (n) begin
            rdEn = 1'b1;
            tick(1);
            rdEn = 1'b0;
            tick(1);
        end
    endtask

    // Scoreboard monitor: every effective pop and every error pulse is matched.
    always begin
        logic [7:0] expByte;
        logic [1:0] expErr;
        @(negedge clk);
        #1;
        if (!reset) begin
            if (rdEn && dataReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL pop data: got 0x%0h expected no byte", data);
                end else begin
                    expByte = expQ.pop_front();
                    if (data !== expByte) begin
                        fails++;
                        $display("[TB] FAIL pop data: got 0x%0h expected 0x%0h", data, expByte);
                    end
                end
            end
            if (error) begin
                checks++;
                if (errQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL error pulse: got errCode %0d expected no error", errCode);
                end else begin
                    expErr = errQ.pop_front();
                    if (errCode !== expErr) begin
                        fails++;
                        $display("[TB] FAIL errCode: got %0d expected %0d", errCode, expErr);
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        rdEn    = 1'b0;
        clrOvf  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        $display("[TB] reset state");
        checkOutput("reset data", 32'(data), 32'h0);
        checkOutput("reset dataReady", 32'(dataReady), 32'h0);
        checkOutput("reset count", 32'(count), 32'h0);
        checkOutput("reset error", 32'(error), 32'h0);
        checkOutput("reset errCode", 32'(errCode), 32'h0);
        checkOutput("reset overflow", 32'(overflow), 32'h0);

        $display("[TB] good frame 0x65");
        expQ.push_back(8'h65);
        applyStimulus(8'h65, 1'b0, 1'b1, 1'b0);
        checkOutput("good data", 32'(data), 32'h65);
        checkOutput("good dataReady", 32'(dataReady), 32'h1);
        checkOutput("good count", 32'(count), 32'h1);
        applyPop(1);
        checkOutput("popped dataReady", 32'(dataReady), 32'h0);
        checkOutput("popped data", 32'(data), 32'h0);

        $display("[TB] parity error then good 0x1C");
        errQ.push_back(2'd1);
        applyStimulus(8'h65, 1'b1, 1'b1, 1'b0);
        checkOutput("parity count", 32'(count), 32'h0);
        checkOutput("parity errCode", 32'(errCode), 32'h1);
        expQ.push_back(8'h1C);
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        checkOutput("after parity data", 32'(data), 32'h1C);
        checkOutput("errCode held", 32'(errCode), 32'h1);
        applyPop(1);

        $display("[TB] overflow with five frames");
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expQ.push_back(8'(i));
            applyStimulus(8'(i), 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ovf count", 32'(count), 32'h4);
        checkOutput("ovf flag", 32'(overflow), 32'h1);
        applyPop(4);
        checkOutput("drained count", 32'(count), 32'h0);
        clrOvf = 1'b1;
        tick(1);
        clrOvf = 1'b0;
        tick(1);
        checkOutput("ovf cleared", 32'(overflow), 32'h0);

        $display("[TB] push and pop on full");
        for (int i = 1; i <= 5; i++) begin
            expQ.push_back(8'(i));
            applyStimulus(8'(i), 1'b0, 1'b1, i == 5);
        end
        checkOutput("full push-pop count", 32'(count), 32'h4);
        checkOutput("full push-pop ovf", 32'(overflow), 32'h0);
        applyPop(4);

        $display("[TB] stop error and timeout");
        errQ.push_back(2'd2);
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b0);
        checkOutput("stop errCode", 32'(errCode), 32'h2);
        checkOutput("stop count", 32'(count), 32'h0);
        errQ.push_back(2'd3);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        ps2Data = 1'b1;
        tick(25);
        checkOutput("timeout errCode", 32'(errCode), 32'h3);
        checkOutput("timeout count", 32'(count), 32'h0);
        expQ.push_back(8'hAA);
        applyStimulus(8'hAA, 1'b0, 1'b1, 1'b0);
        checkOutput("after timeout data", 32'(data), 32'hAA);
        applyPop(1);

        $display("[TB] glitches before start bit");
        for (int i = 0; i < 3; i++) begin
            ps2Data = 1'b0;
            ps2Clk  = 1'b0;
            tick(1);
            ps2Clk  = 1'b1;
            tick(3);
        end
        ps2Data = 1'b1;
        tick(30);
        checkOutput("glitch count", 32'(count), 32'h0);
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
        checkOutput("after glitch data", 32'(data), 32'h5A);
        applyPop(1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b0);
        errQ.push_back(2'd1);
        applyStimulus(8'h22, 1'b1, 1'b1, 1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        reset = 1'b1;
        tick(2);
        checkOutput("midreset data", 32'(data), 32'h0);
        checkOutput("midreset dataReady", 32'(dataReady), 32'h0);
        checkOutput("midreset count", 32'(count), 32'h0);
        checkOutput("midreset errCode", 32'(errCode), 32'h0);
        reset = 1'b0;
        tick(3);
        expQ.push_back(8'h77);
        applyStimulus(8'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("after reset data", 32'(data), 32'h77);
        applyPop(1);

`ifdef PS2_RX_INHIBIT_EN
        $display("[TB] host inhibit");
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(8'h40 + 8'(i));
            applyStimulus(8'h40 + 8'(i), 1'b0, 1'b1, 1'b0);
        end
        tick(2);
        checkOutput("inhibit on", 32'(ps2ClkOe), 32'h1);
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        tick(1);
        checkOutput("inhibit off", 32'(ps2ClkOe), 32'h0);
        applyPop(3);
`endif

        tick(4);
        checkOutput("expected bytes left", 32'(expQ.size()), 32'h0);
        checkOutput("expected errors left", 32'(errQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
